// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - register-file debug dump engine over a valid/ready stream; optional checksum beat via REGDUMP_CHECKSUM_EN
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic [ADDR_W-1:0] Dump_reg,
  input  logic [DATA_W-1:0] Dump_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_is_sum,
  output logic              done
);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_SUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] index;
  logic              last_reg;
  logic              accept;

  // A beat is only taken when no abort arrives in the same cycle
  assign accept   = out_valid & out_ready & ~abort;
  assign last_reg = (index == LAST_IDX);

  // The index only moves on entry to READ, so it doubles as the read-port address
  assign Dump_reg = index;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and Moore outputs; abort overrides everything outside IDLE
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    out_valid = 1'b0;
    done      = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
    out_is_sum = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_READ;
      end
      S_READ: state_nxt = S_SEND;
      S_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
          state_nxt = last_reg ? S_SUM : S_READ;
`else
          state_nxt = last_reg ? S_DONE : S_READ;
`endif
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_SUM: begin
        out_valid  = 1'b1;
        out_is_sum = 1'b1;
        if (out_ready) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  // Running XOR of every register captured in READ, cleared when a dump starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         checksum <= '0;
    else if (state == S_IDLE && start)  checksum <= '0;
    else if (state == S_READ)           checksum <= checksum ^ Dump_data;
  end
`else
  assign out_is_sum = 1'b0;
`endif

  // Register index walk and beat payload capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index    <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      if (state == S_IDLE && start)
        index <= '0;
      else if (state == S_SEND && accept && !last_reg)
        index <= index + ADDR_W'(1);

      if (state == S_READ) begin
        out_data <= Dump_data;
        out_addr <= index;
      end
`ifdef REGDUMP_CHECKSUM_EN
      else if (state == S_SEND && accept && last_reg) begin
        out_data <= checksum;
        out_addr <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - randomized self-checking bench for regfile_dump against a register-array model
module tb_regfile_dump;
  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic [4:0]  Dump_reg;
  logic [31:0] Dump_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_is_sum;
  logic        done;

  logic [31:0] regs [N];

  int errors = 0;
  int checks = 0;

  // captured beats of the most recent dump
  logic [4:0]  got_addr [$];
  logic [31:0] got_data [$];
  logic        got_sum  [$];
  int          got_cyc  [$];
  int          done_cycle;
  logic        done_busy;
  logic        busy_after;
  int          unstable;

  // expected beats built from the register contents
  logic [4:0]  exp_addr [$];
  logic [31:0] exp_data [$];
  logic        exp_sum  [$];

  always #5 clk = ~clk;

  assign Dump_data = regs[Dump_reg];

  regfile_dump dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
    .Dump_reg(Dump_reg), .Dump_data(Dump_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_is_sum(out_is_sum), .done(done)
  );

  task automatic build_expected();
    logic [31:0] x;
    x = 32'h0;
    exp_addr.delete(); exp_data.delete(); exp_sum.delete();
    for (int i = 0; i < N; i++) begin
      exp_addr.push_back(5'(i));
      exp_data.push_back(regs[i]);
      exp_sum.push_back(1'b0);
      x ^= regs[i];
    end
`ifdef REGDUMP_CHECKSUM_EN
    exp_addr.push_back(5'd0);
    exp_data.push_back(x);
    exp_sum.push_back(1'b1);
`endif
  endtask

  // Drives one dump to completion and records every accepted beat with its cycle number
  task automatic run_dump(input int ready_pct, input bit poke_start);
    int          cyc;
    logic        hold_v;
    logic [4:0]  hold_a;
    logic [31:0] hold_d;
    logic        hold_s;
    got_addr.delete(); got_data.delete(); got_sum.delete(); got_cyc.delete();
    done_cycle = -1; done_busy = 1'b0; busy_after = 1'b1; unstable = 0;
    hold_v = 1'b0; hold_a = '0; hold_d = '0; hold_s = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (done_cycle < 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = poke_start && (cyc == 10 || cyc == 11);
      if (hold_v && (!out_valid || out_addr !== hold_a || out_data !== hold_d || out_is_sum !== hold_s))
        unstable++;
      if (done === 1'b1) begin
        done_cycle = cyc;
        done_busy  = busy;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
        got_sum.push_back(out_is_sum);
        got_cyc.push_back(cyc);
        hold_v = 1'b0;
      end else begin
        hold_v = out_valid; hold_a = out_addr; hold_d = out_data; hold_s = out_is_sum;
      end
    end
    start = 1'b0;
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic compare_beats(input string tag);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL %s beat_count: got %0d want %0d", tag, got_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_sum[i] !== exp_sum[i]) begin
          errors++;
          $display("FAIL %s beat%0d: got addr=%0d data=%h sum=%b want addr=%0d data=%h sum=%b",
                   tag, i, got_addr[i], got_data[i], got_sum[i], exp_addr[i], exp_data[i], exp_sum[i]);
        end
      end
    end
    checks++;
    if (done_cycle < 0) begin
      errors++;
      $display("FAIL %s done_timeout: got none want done pulse", tag);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL %s stall_stability: got %0d changes want 0", tag, unstable);
    end
    checks++;
    if (done_busy !== 1'b1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_around_done: got busy@done=%b busy_after=%b want 1/0", tag, done_busy, busy_after);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, Dump_reg, out_valid, out_addr, out_data, out_is_sum, done} !== '0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b reg=%0d v=%b a=%0d d=%h s=%b done=%b want all 0",
               busy, Dump_reg, out_valid, out_addr, out_data, out_is_sum, done);
    end
  endtask

  task automatic test_preload_dump();
    int want_done;
    for (int i = 0; i < N; i++) regs[i] = 32'h1000_0000 + 32'(i);
    build_expected();
    run_dump(100, 1'b0);
    compare_beats("preload");
`ifdef REGDUMP_CHECKSUM_EN
    want_done = 2 * N + 2;
`else
    want_done = 2 * N + 1;
`endif
    checks++;
    if (done_cycle != want_done) begin
      errors++;
      $display("FAIL preload_done_cycle: got %0d want %0d", done_cycle, want_done);
    end
    checks++;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < got_cyc.size(); i++)
        if (got_cyc[i] != 2 + 2 * i) bad++;
      if (bad != 0 || got_cyc.size() == 0) begin
        errors++;
        $display("FAIL preload_beat_spacing: got %0d off-slot beats of %0d want 0", bad, got_cyc.size());
      end
    end
  endtask

  task automatic test_random_backpressure();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) regs[i] = $urandom;
      build_expected();
      run_dump(30 + 20 * r, 1'b0);
      compare_beats("backpressure");
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    build_expected();
    run_dump(70, 1'b1);
    compare_beats("start_busy");
  endtask

  task automatic test_abort();
    int  cyc;
    bit  saw_done;
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    @(negedge clk);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_addr == 5'd7) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      out_ready = !(out_valid && out_addr == 5'd7);
    end
    out_ready = 1'b0;
    checks++;
    if (!(out_valid && out_addr == 5'd7)) begin
      errors++;
      $display("FAIL abort_reach_reg7: got valid=%b addr=%0d want 1/7", out_valid, out_addr);
    end
    @(negedge clk);
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_cycle: got valid=%b busy=%b done=%b want 0/0/0", out_valid, busy, done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_quiet: got done/busy activity want none");
    end
    build_expected();
    run_dump(100, 1'b0);
    compare_beats("after_abort");
  endtask

  task automatic test_async_reset();
    int cyc;
    for (int i = 0; i < N; i++) regs[i] = $urandom | 32'h1;
    @(negedge clk);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_addr == 5'd12) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!(out_valid && out_addr == 5'd12)) begin
      errors++;
      $display("FAIL reset_reach_reg12: got valid=%b addr=%0d want 1/12", out_valid, out_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, Dump_reg, out_valid, out_addr, out_data, out_is_sum, done} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b reg=%0d v=%b a=%0d d=%h s=%b done=%b want all 0",
               busy, Dump_reg, out_valid, out_addr, out_data, out_is_sum, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b want 0/0", busy, out_valid);
    end
    build_expected();
    run_dump(100, 1'b0);
    compare_beats("after_reset");
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_preload_dump();
    test_random_backpressure();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
